// File: rtl/fs_accel_pkg.sv
// Shared constants for the accelerator output requantize-and-pack stage.
package fs_accel_pkg;

  localparam int unsigned ACC_W_DEF = 32;
  localparam int unsigned MUL_W_DEF = 16;
  localparam int unsigned SH_W_DEF  = 5;

  localparam int unsigned LANES  = 4;
  localparam int          I8_MIN = -128;
  localparam int          I8_MAX = 127;

endpackage

// File: rtl/fs_accel_requant.sv
// Combinational round-half-up shift, zero-point add, optional ReLU and int8 saturation.
module fs_accel_requant
  import fs_accel_pkg::*;
#(
  parameter int unsigned P_W  = 49,
  parameter int unsigned SH_W = SH_W_DEF
) (
  input  logic signed [P_W-1:0]  p,
  input  logic        [SH_W-1:0] shift,
  input  logic        [7:0]      zp,
  input  logic                   relu_en,
  output logic        [7:0]      q
);

  // One guard bit so the rounding add can never wrap.
  localparam int unsigned W = P_W + 1;

  logic signed [W-1:0] pe, rnd, r, zpe, v_add, v_relu, hi, lo;

  assign pe  = {p[P_W-1], p};
  assign zpe = {{(W-8){zp[7]}}, zp};
  assign hi  = W'(I8_MAX);
  assign lo  = W'(I8_MIN);

  always_comb begin
    rnd = '0;
    if (shift != '0) begin
      rnd = W'(1) <<< (shift - SH_W'(1));
    end
    r      = (pe + rnd) >>> shift;
    v_add  = r + zpe;
    v_relu = (relu_en && (v_add < zpe)) ? zpe : v_add;
    if (v_relu > hi) begin
      q = 8'h7f;
    end else if (v_relu < lo) begin
      q = 8'h80;
    end else begin
      q = v_relu[7:0];
    end
  end

endmodule

// File: rtl/fs_accel_opack.sv
// Three-stage requantize pipeline (multiply, requant, pack) feeding the output buffer.
module fs_accel_opack
  import fs_accel_pkg::*;
#(
  parameter int unsigned ACC_W = ACC_W_DEF,
  parameter int unsigned MUL_W = MUL_W_DEF,
  parameter int unsigned SH_W  = SH_W_DEF
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             enb,
  input  logic [ACC_W-1:0] acc_di,
  input  logic             acc_valid,
  input  logic             acc_last,
  output logic             acc_ready,
  input  logic [MUL_W-1:0] quant_mult,
  input  logic [SH_W-1:0]  quant_shift,
  input  logic [7:0]       quant_zp,
  input  logic             relu_en,
  output logic [31:0]      obuf_di,
  output logic             obuf_ld_wrn,
  output logic             busy
);

  localparam int unsigned P_W   = ACC_W + MUL_W + 1;
  localparam int unsigned CNT_W = $clog2(LANES);

  logic signed [P_W-1:0]   acc_ext, mult_ext, p1_d, p1_q;
  logic                    valid1_q, last1_q;
  logic        [7:0]       byte_d, byte2_q;
  logic                    valid2_q, last2_q;
  logic        [CNT_W-1:0] cnt_d, cnt_q;
  logic        [31:0]      pack_d, pack_q, merged;
  logic        [31:0]      word_d, word_q;
  logic                    ld_d, ld_q;

  assign acc_ready = enb;

  // Product fits exactly in P_W bits, so the truncated multiply loses nothing.
  assign acc_ext  = {{(P_W-ACC_W){acc_di[ACC_W-1]}}, acc_di};
  assign mult_ext = {{(P_W-MUL_W){1'b0}}, quant_mult};
  assign p1_d     = acc_ext * mult_ext;

  fs_accel_requant #(
    .P_W  (P_W),
    .SH_W (SH_W)
  ) u_requant (
    .p       (p1_q),
    .shift   (quant_shift),
    .zp      (quant_zp),
    .relu_en (relu_en),
    .q       (byte_d)
  );

  always_comb begin
    merged = pack_q | (32'(byte2_q) << {cnt_q, 3'b000});
    cnt_d  = cnt_q;
    pack_d = pack_q;
    word_d = word_q;
    ld_d   = 1'b0;
    if (valid2_q) begin
      if ((cnt_q == CNT_W'(LANES - 1)) || last2_q) begin
        word_d = merged;
        ld_d   = 1'b1;
        cnt_d  = '0;
        pack_d = '0;
      end else begin
        pack_d = merged;
        cnt_d  = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      p1_q     <= '0;
      valid1_q <= 1'b0;
      last1_q  <= 1'b0;
      byte2_q  <= '0;
      valid2_q <= 1'b0;
      last2_q  <= 1'b0;
      cnt_q    <= '0;
      pack_q   <= '0;
      word_q   <= '0;
      ld_q     <= 1'b0;
    end else if (enb) begin
      p1_q     <= p1_d;
      valid1_q <= acc_valid;
      last1_q  <= acc_valid && acc_last;
      byte2_q  <= byte_d;
      valid2_q <= valid1_q;
      last2_q  <= last1_q;
      cnt_q    <= cnt_d;
      pack_q   <= pack_d;
      word_q   <= word_d;
      ld_q     <= ld_d;
    end
  end

  assign obuf_di     = word_q;
  assign obuf_ld_wrn = ld_q;
  assign busy        = valid1_q | valid2_q | (cnt_q != '0) | ld_q;

endmodule

// File: tb/tb_fs_accel_opack.sv
// Directed and randomized checks of fs_accel_opack against an arithmetic reference model.
module tb_fs_accel_opack;

  logic        clk = 1'b0;
  logic        resetn;
  logic        enb;
  logic [31:0] acc_di;
  logic        acc_valid;
  logic        acc_last;
  logic        acc_ready;
  logic [15:0] quant_mult;
  logic [4:0]  quant_shift;
  logic [7:0]  quant_zp;
  logic        relu_en;
  logic [31:0] obuf_di;
  logic        obuf_ld_wrn;
  logic        busy;

  fs_accel_opack dut (
    .clk         (clk),
    .resetn      (resetn),
    .enb         (enb),
    .acc_di      (acc_di),
    .acc_valid   (acc_valid),
    .acc_last    (acc_last),
    .acc_ready   (acc_ready),
    .quant_mult  (quant_mult),
    .quant_shift (quant_shift),
    .quant_zp    (quant_zp),
    .relu_en     (relu_en),
    .obuf_di     (obuf_di),
    .obuf_ld_wrn (obuf_ld_wrn),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;
  int n_words  = 0;
  int n_strobes = 0;

  logic [31:0] exp_q[$];
  logic [7:0]  lanes[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] ref_byte(input int acc, input int unsigned mult, input int sh,
                                          input int zp, input bit relu);
    longint p, r, v;
    p = longint'(acc) * longint'(mult);
    if (sh == 0) r = p;
    else r = (p + (longint'(1) <<< (sh - 1))) >>> sh;
    v = r + longint'(zp);
    if (relu && v < zp) v = zp;
    if (v > 127) v = 127;
    if (v < -128) v = -128;
    return v[7:0];
  endfunction

  task automatic model_accept(input int acc, input bit last);
    logic [31:0] w;
    lanes.push_back(ref_byte(acc, quant_mult, int'(quant_shift), int'($signed(quant_zp)), relu_en));
    if (lanes.size() == 4 || last) begin
      w = '0;
      foreach (lanes[i]) w[8*i +: 8] = lanes[i];
      exp_q.push_back(w);
      n_words++;
      lanes.delete();
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int acc, input bit last);
    acc_di    = acc;
    acc_valid = 1'b1;
    acc_last  = last;
    if (enb) model_accept(acc, last);
    tick();
    acc_valid = 1'b0;
    acc_last  = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    enb = 1'b1;
    for (int i = 0; i < 50 && (busy || exp_q.size() != 0); i++) tick();
    check({tag, "_busy"}, busy, 0);
    check({tag, "_words"}, exp_q.size(), 0);
  endtask

  task automatic set_cfg(input int mult, input int sh, input int zp, input bit relu);
    quant_mult  = 16'(mult);
    quant_shift = 5'(sh);
    quant_zp    = 8'(zp);
    relu_en     = relu;
  endtask

  // Strobe monitor: every enabled strobe cycle consumes one expected word.
  always @(negedge clk) begin
    if (resetn && obuf_ld_wrn) begin
      check("strobe_pending", exp_q.size() > 0, 1);
      if (exp_q.size() > 0) begin
        check(enb ? "word" : "word_hold", obuf_di, exp_q[0]);
        if (enb) begin
          void'(exp_q.pop_front());
          n_strobes++;
        end
      end
    end
  end

  initial begin
    resetn = 1'b0; enb = 1'b0; acc_di = '0; acc_valid = 1'b0; acc_last = 1'b0;
    set_cfg(16384, 14, 0, 0);
    repeat (2) tick();
    check("rst_obuf_di", obuf_di, 0);
    check("rst_ld", obuf_ld_wrn, 0);
    check("rst_busy", busy, 0);
    check("ready_off", acc_ready, 0);
    resetn = 1'b1;
    tick();
    enb = 1'b1;
    #1 check("ready_on", acc_ready, 1);

    // Basic burst with latency measurement
    send(5, 0); send(-3, 0); send(200, 0); send(-200, 0);
    @(negedge clk) check("lat_c1", obuf_ld_wrn, 0);
    @(negedge clk) check("lat_c2", obuf_ld_wrn, 0);
    @(negedge clk) check("lat_c3", obuf_ld_wrn, 1);
    check("lat_word", obuf_di, 32'h807FFD05);
    tick();
    wait_idle("basic");

    set_cfg(16384, 14, 0, 1);
    send(5, 0); send(-3, 0); send(200, 0); send(-200, 0);
    wait_idle("relu");
    check("relu_word", obuf_di, 32'h007F0005);

    set_cfg(1, 1, 0, 0);
    send(3, 0); send(-3, 0); send(1, 0); send(-1, 0);
    wait_idle("round");
    check("round_word", obuf_di, 32'h0001FF02);

    set_cfg(16384, 14, 0, 0);
    send(1, 0); send(2, 1);
    wait_idle("partial");
    check("partial_word", obuf_di, 32'h00000201);
    send(9, 0); send(8, 0); send(7, 0); send(6, 0);
    wait_idle("after_partial");
    check("after_partial_word", obuf_di, 32'h06070809);

    send(21, 0); send(22, 0); send(23, 0); send(24, 1);
    wait_idle("last_lane3");
    check("last_lane3_word", obuf_di, 32'h18171615);

    // Stall mid-burst (junk on input is ignored), then stall on the strobe itself
    send(1, 0); send(2, 0);
    enb = 1'b0;
    repeat (5) send(99, 0);
    enb = 1'b1;
    send(3, 0); send(4, 0);
    tick(); tick();
    enb = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall_ld", obuf_ld_wrn, 1);
      check("stall_word", obuf_di, 32'h04030201);
      tick();
    end
    enb = 1'b1;
    @(negedge clk) check("stall_pulse", obuf_ld_wrn, 1);
    tick();
    @(negedge clk) check("stall_pulse_end", obuf_ld_wrn, 0);
    tick();
    wait_idle("stall");
    check("stall_final", obuf_di, 32'h04030201);

    // Asynchronous reset with two elements in flight
    send(1, 0); send(2, 0);
    #2 resetn = 1'b0;
    #1;
    check("arst_obuf_di", obuf_di, 0);
    check("arst_ld", obuf_ld_wrn, 0);
    check("arst_busy", busy, 0);
    lanes.delete();
    exp_q.delete();
    tick(); tick();
    resetn = 1'b1;
    tick();
    send(11, 0); send(12, 0); send(13, 0); send(14, 0);
    wait_idle("post_reset");
    check("post_reset_word", obuf_di, 32'h0E0D0C0B);

    // Randomized tiles with random enable gaps; config changes only when idle
    for (int t = 0; t < 40; t++) begin
      int len;
      set_cfg($urandom_range(0, 65535), $urandom_range(0, 24), $urandom_range(0, 255),
              1'($urandom_range(0, 1)));
      len = $urandom_range(1, 9);
      for (int e = 0; e < len; e++) begin
        enb = (e == len - 1) ? 1'b1 : 1'($urandom_range(0, 4) != 0);
        send(int'($urandom) >>> $urandom_range(0, 30), e == len - 1);
      end
      enb = 1'($urandom_range(0, 1));
      tick();
      wait_idle("rand");
    end

    check("strobe_count", n_strobes, n_words);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
